// File: rtl/mem_line_requester.sv
// Single-outstanding cache-line initiator for the tagged mem_req / mem_req_data / mem_resp protocol.
// A write streams LINE_BEATS data beats after its request. A read gathers LINE_BEATS tagged response beats into one line.
module mem_line_requester #(
    parameter int ADDR_BITS  = 28,
    parameter int DATA_BITS  = 128,
    parameter int TAG_BITS   = 5,
    parameter int LINE_BEATS = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_rw,
    input  logic [ADDR_BITS-1:0]               cmd_addr,
    input  logic [LINE_BEATS*DATA_BITS-1:0]    cmd_wdata,
    input  logic [LINE_BEATS*DATA_BITS/8-1:0]  cmd_wmask,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic                               rsp_rw,
    output logic [LINE_BEATS*DATA_BITS-1:0]    rsp_data,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic                               mem_req_rw,
    output logic [ADDR_BITS-1:0]               mem_req_addr,
    output logic [TAG_BITS-1:0]                mem_req_tag,
    output logic                               mem_req_data_valid,
    input  logic                               mem_req_data_ready,
    output logic [DATA_BITS-1:0]               mem_req_data_bits,
    output logic [DATA_BITS/8-1:0]             mem_req_data_mask,
    input  logic                               mem_resp_valid,
    input  logic [TAG_BITS-1:0]                mem_resp_tag,
    input  logic [DATA_BITS-1:0]               mem_resp_data,
    output logic                               tag_err
);

    localparam int LINE_BITS = LINE_BEATS * DATA_BITS;
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int BEAT_BITS = $clog2(LINE_BEATS);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WDATA,
        S_RRESP,
        S_RSP
    } state_t;

    state_t                          r_state;
    logic                            r_cmd_ready;
    logic                            r_req_valid;
    logic                            r_wvalid;
    logic                            r_rsp_valid;
    logic                            r_rw;
    logic [ADDR_BITS-1:0]            r_addr;
    logic [TAG_BITS-1:0]             r_tag;
    logic [TAG_BITS-1:0]             r_tag_cnt;
    logic [BEAT_BITS-1:0]            r_beat;
    logic [LINE_BITS-1:0]            r_wdata;
    logic [LINE_BEATS*MASK_BITS-1:0] r_wmask;
    logic [LINE_BITS-1:0]            r_line;
    logic                            r_tag_err;

    logic w_resp_ok;

    // Only a beat carrying our tag while collecting a read is legal; anything else is flagged and dropped.
    assign w_resp_ok = mem_resp_valid && (r_state == S_RRESP) && (mem_resp_tag == r_tag);

    assign cmd_ready          = r_cmd_ready;
    assign mem_req_valid      = r_req_valid;
    assign mem_req_rw         = r_rw;
    assign mem_req_addr       = r_addr;
    assign mem_req_tag        = r_tag;
    assign mem_req_data_valid = r_wvalid;
    assign mem_req_data_bits  = r_wdata[r_beat*DATA_BITS +: DATA_BITS];
    assign mem_req_data_mask  = r_wmask[r_beat*MASK_BITS +: MASK_BITS];
    assign rsp_valid          = r_rsp_valid;
    assign rsp_rw             = r_rw;
    assign rsp_data           = r_line;
    assign tag_err            = r_tag_err;

    // NOTE: every register here uses <= so all of them sample pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_req_valid <= 1'b0;
            r_wvalid    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_tag       <= '0;
            r_tag_cnt   <= '0;
            r_beat      <= '0;
            // NOTE: the line buffers are reset too, because rsp_data and the write-beat outputs must read 0 out of reset.
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_line      <= '0;
            r_tag_err   <= 1'b0;
        end else begin
            if (mem_resp_valid && !w_resp_ok) begin
                r_tag_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_rw        <= cmd_rw;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wmask     <= cmd_wmask;
                        r_tag       <= r_tag_cnt;
                        r_line      <= '0;
                        r_state     <= S_REQ;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_tag_cnt   <= r_tag_cnt + 1'b1;
                        if (r_rw) begin
                            r_wvalid <= 1'b1;
                            r_state  <= S_WDATA;
                        end else begin
                            r_state  <= S_RRESP;
                        end
                    end
                end

                S_WDATA: begin
                    if (mem_req_data_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_wvalid    <= 1'b0;
                            r_beat      <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RSP;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end

                S_RRESP: begin
                    if (w_resp_ok) begin
                        r_line[r_beat*DATA_BITS +: DATA_BITS] <= mem_resp_data;
                        if (r_beat == LAST_BEAT) begin
                            r_beat      <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RSP;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_requester.sv
// Directed bench for mem_line_requester: the bench itself plays both the client and the memory responder.
module tb_mem_line_requester;

    localparam int AB = 28;
    localparam int DB = 128;
    localparam int TB = 5;
    localparam int LB = 4;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic                   cmd_rw = 1'b0;
    logic [AB-1:0]          cmd_addr = '0;
    logic [LB*DB-1:0]       cmd_wdata = '0;
    logic [LB*DB/8-1:0]     cmd_wmask = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic                   rsp_rw;
    logic [LB*DB-1:0]       rsp_data;
    logic                   mem_req_valid;
    logic                   mem_req_ready = 1'b0;
    logic                   mem_req_rw;
    logic [AB-1:0]          mem_req_addr;
    logic [TB-1:0]          mem_req_tag;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready = 1'b0;
    logic [DB-1:0]          mem_req_data_bits;
    logic [DB/8-1:0]        mem_req_data_mask;
    logic                   mem_resp_valid = 1'b0;
    logic [TB-1:0]          mem_resp_tag = '0;
    logic [DB-1:0]          mem_resp_data = '0;
    logic                   tag_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_line_requester #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .TAG_BITS  (TB),
        .LINE_BEATS(LB)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_rw            (cmd_rw),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .cmd_wmask         (cmd_wmask),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rw            (rsp_rw),
        .rsp_data          (rsp_data),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_rw        (mem_req_rw),
        .mem_req_addr      (mem_req_addr),
        .mem_req_tag       (mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid),
        .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits (mem_req_data_bits),
        .mem_req_data_mask (mem_req_data_mask),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_tag      (mem_resp_tag),
        .mem_resp_data     (mem_resp_data),
        .tag_err           (tag_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        cmd_valid = 1'b0; mem_req_ready = 1'b0; mem_req_data_ready = 1'b0;
        mem_resp_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_cmd_ready(input string name);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL %s: cmd_ready never rose within 50 cycles", name);
        end
    endtask

    task automatic pop_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Issues one read, answers it with base+0..base+3 (optionally preceded by a wrong-tag beat), stops at rsp_valid.
    task automatic do_read(input logic [AB-1:0] addr, input logic [DB-1:0] base, input bit bad_beat,
                           output logic [TB-1:0] tag, output logic [LB*DB-1:0] line,
                           output int lat, output bit req_ok);
        cmd_rw = 1'b0; cmd_addr = addr; cmd_valid = 1'b1;
        wait_cmd_ready("read_cmd_ready");
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        tag = mem_req_tag;
        req_ok = mem_req_valid && !mem_req_rw && (mem_req_addr == addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        lat++;
        for (int b = 0; b < LB; b++) begin
            if (bad_beat && b == 1) begin
                mem_resp_valid = 1'b1; mem_resp_tag = tag + 5'd1; mem_resp_data = '1;
                tick();
                lat++;
            end
            mem_resp_valid = 1'b1; mem_resp_tag = tag; mem_resp_data = base + DB'(b);
            tick();
            lat++;
        end
        mem_resp_valid = 1'b0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        line = rsp_data;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({cmd_ready, mem_req_valid, mem_req_data_valid, rsp_valid, tag_err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000",
                     {cmd_ready, mem_req_valid, mem_req_data_valid, rsp_valid, tag_err});
        end
        n_cmp++;
        if (rsp_data !== '0) begin
            n_err++;
            $display("FAIL reset_rsp_data: got %h want 0", rsp_data);
        end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: cmd_ready=%b mem_req_valid=%b want 1/0", cmd_ready, mem_req_valid);
        end
    endtask

    task automatic test_read();
        logic [TB-1:0] tag;
        logic [LB*DB-1:0] line;
        int lat;
        bit ok;
        do_read(28'h0000123, 128'hA0, 1'b0, tag, line, lat, ok);
        n_cmp++;
        if (!ok || tag !== 5'd0) begin
            n_err++;
            $display("FAIL read_req: fields_ok=%b tag=%0d want 1/0", ok, tag);
        end
        n_cmp++;
        if (lat != 5) begin
            n_err++;
            $display("FAIL read_latency: got %0d cycles want 5", lat);
        end
        n_cmp++;
        if (line !== {128'hA3, 128'hA2, 128'hA1, 128'hA0}) begin
            n_err++;
            $display("FAIL read_data: got %h", line);
        end
        n_cmp++;
        if ({rsp_valid, rsp_rw, cmd_ready, tag_err} !== 4'b1000) begin
            n_err++;
            $display("FAIL read_rsp_flags: got %b want 1000", {rsp_valid, rsp_rw, cmd_ready, tag_err});
        end
        pop_rsp();
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL read_pop: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_write_backpressure();
        logic [DB-1:0]   exp_bits [LB];
        logic [DB/8-1:0] exp_mask [LB];
        logic [DB-1:0]   got_bits [LB];
        logic [DB/8-1:0] got_mask [LB];
        int n = 0;
        int k = 0;
        int bad = 0;
        exp_mask = '{16'hFFFF, 16'h00FF, 16'hF0F0, 16'h8001};
        for (int i = 0; i < LB; i++) begin
            exp_bits[i] = {4{32'hC0DE_0000 + 32'(i)}};
            got_bits[i] = '0;
            got_mask[i] = '0;
        end
        cmd_rw = 1'b1; cmd_addr = 28'h0BEEF40;
        cmd_wdata = {exp_bits[3], exp_bits[2], exp_bits[1], exp_bits[0]};
        cmd_wmask = {exp_mask[3], exp_mask[2], exp_mask[1], exp_mask[0]};
        cmd_valid = 1'b1;
        wait_cmd_ready("write_cmd_ready");
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 28'h0BEEF40 ||
                mem_req_tag !== 5'd1 || mem_req_data_valid !== 1'b0)
                bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL write_req_stall: %0d of 3 stalled cycles had wrong request fields", bad);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        while (!rsp_valid && k < 30) begin
            mem_req_data_ready = (k % 2 == 0);
            if (mem_req_data_valid && mem_req_data_ready) begin
                if (n < LB) begin
                    got_bits[n] = mem_req_data_bits;
                    got_mask[n] = mem_req_data_mask;
                end
                n++;
            end
            tick();
            k++;
        end
        mem_req_data_ready = 1'b0;
        n_cmp++;
        if (n != LB) begin
            n_err++;
            $display("FAIL write_beat_count: got %0d want 4", n);
        end
        for (int i = 0; i < LB; i++) begin
            n_cmp++;
            if (got_bits[i] !== exp_bits[i] || got_mask[i] !== exp_mask[i]) begin
                n_err++;
                $display("FAIL write_beat%0d: got %h/%h want %h/%h", i, got_bits[i], got_mask[i],
                         exp_bits[i], exp_mask[i]);
            end
        end
        n_cmp++;
        if ({rsp_valid, rsp_rw, mem_req_data_valid} !== 3'b110 || rsp_data !== '0) begin
            n_err++;
            $display("FAIL write_rsp: valid/rw/dvalid=%b want 110, rsp_data=%h want 0",
                     {rsp_valid, rsp_rw, mem_req_data_valid}, rsp_data);
        end
        pop_rsp();
    endtask

    task automatic test_tag_wrap();
        logic [TB-1:0] tag;
        logic [LB*DB-1:0] line;
        int lat;
        bit ok;
        apply_reset();
        for (int i = 0; i < 33; i++) begin
            do_read(AB'(i), DB'(i * 16), 1'b0, tag, line, lat, ok);
            n_cmp++;
            if (!ok || tag !== 5'(i)) begin
                n_err++;
                $display("FAIL tag_wrap_%0d: fields_ok=%b tag=%0d want 1/%0d", i, ok, tag, i % 32);
            end
            pop_rsp();
        end
        n_cmp++;
        if (tag_err !== 1'b0) begin
            n_err++;
            $display("FAIL tag_wrap_err: tag_err=%b want 0", tag_err);
        end
    endtask

    task automatic test_wrong_tag();
        logic [TB-1:0] tag;
        logic [LB*DB-1:0] line;
        int lat;
        bit ok;
        do_read(28'h0000ABC, 128'h2000, 1'b1, tag, line, lat, ok);
        n_cmp++;
        if (tag !== 5'd1 || lat != 6) begin
            n_err++;
            $display("FAIL wrong_tag_req: tag=%0d lat=%0d want 1/6", tag, lat);
        end
        n_cmp++;
        if (line !== {128'h2003, 128'h2002, 128'h2001, 128'h2000}) begin
            n_err++;
            $display("FAIL wrong_tag_data: got %h", line);
        end
        n_cmp++;
        if (tag_err !== 1'b1) begin
            n_err++;
            $display("FAIL wrong_tag_flag: tag_err=%b want 1", tag_err);
        end
        pop_rsp();
        repeat (3) tick();
        n_cmp++;
        if (tag_err !== 1'b1) begin
            n_err++;
            $display("FAIL wrong_tag_sticky: tag_err=%b want 1", tag_err);
        end
    endtask

    task automatic test_rsp_backpressure();
        logic [TB-1:0] tag;
        logic [LB*DB-1:0] line;
        int lat;
        bit ok;
        int bad = 0;
        do_read(28'h0000456, 128'h1000, 1'b0, tag, line, lat, ok);
        n_cmp++;
        if (tag !== 5'd2 || line !== {128'h1003, 128'h1002, 128'h1001, 128'h1000}) begin
            n_err++;
            $display("FAIL bp_read: tag=%0d want 2, data=%h", tag, line);
        end
        cmd_rw = 1'b0; cmd_addr = 28'h0000789; cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== line || cmd_ready !== 1'b0 || mem_req_valid !== 1'b0)
                bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold: %0d of 10 held cycles were not stable", bad);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h0000789 || mem_req_tag !== 5'd3) begin
            n_err++;
            $display("FAIL bp_next_cmd: valid=%b addr=%h tag=%0d want 1/0000789/3",
                     mem_req_valid, mem_req_addr, mem_req_tag);
        end
    endtask

    task automatic test_async_reset();
        logic [TB-1:0] tag;
        logic [LB*DB-1:0] line;
        int lat;
        bit ok;
        int stray = 0;
        apply_reset();
        cmd_rw = 1'b1; cmd_addr = 28'h0ABCDE0;
        cmd_wdata = {4{128'h5A5A_5A5A_1234_5678_9ABC_DEF0_0F0F_0F0F}};
        cmd_wmask = '1;
        cmd_valid = 1'b1;
        wait_cmd_ready("areset_cmd_ready");
        tick();
        cmd_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_req_data_ready = 1'b1;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, mem_req_valid, mem_req_data_valid, rsp_valid, tag_err} !== 5'b0) begin
            n_err++;
            $display("FAIL areset_flags: got %b want 00000",
                     {cmd_ready, mem_req_valid, mem_req_data_valid, rsp_valid, tag_err});
        end
        n_cmp++;
        if (mem_req_data_bits !== '0 || mem_req_addr !== '0 || rsp_data !== '0) begin
            n_err++;
            $display("FAIL areset_data: bits=%h addr=%h rsp_data=%h want 0", mem_req_data_bits,
                     mem_req_addr, rsp_data);
        end
        #2 reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (mem_req_data_valid !== 1'b0) stray++;
        end
        mem_req_data_ready = 1'b0;
        n_cmp++;
        if (stray != 0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL areset_after: stray beats=%0d cmd_ready=%b want 0/1", stray, cmd_ready);
        end
        do_read(28'h0000321, 128'h3000, 1'b0, tag, line, lat, ok);
        n_cmp++;
        if (!ok || tag !== 5'd0 || line !== {128'h3003, 128'h3002, 128'h3001, 128'h3000}) begin
            n_err++;
            $display("FAIL areset_tag_restart: fields_ok=%b tag=%0d want 1/0, data=%h", ok, tag, line);
        end
        pop_rsp();
    endtask

    task automatic test_stray_resp();
        n_cmp++;
        if (tag_err !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stray_pre: tag_err=%b cmd_ready=%b want 0/1", tag_err, cmd_ready);
        end
        mem_resp_valid = 1'b1; mem_resp_tag = 5'd0; mem_resp_data = 128'h77;
        tick();
        mem_resp_valid = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (tag_err !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stray_idle_beat: tag_err=%b rsp_valid=%b want 1/0", tag_err, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_tag_wrap();
        test_wrong_tag();
        test_rsp_backpressure();
        test_async_reset();
        test_stray_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
